// File: rtl/phy_tx_pkg.sv
// rtl/phy_tx_pkg.sv - shared symbols, FSM encoding and output-symbol type for the PHY transmit scheduler
//
// Purpose : constants and types shared by phy_tx_sched and its interface.
// Contents: COM_SYM / IDL_SYM control symbols, ST_* FSM encodings,
//           ser_sym_t (one registered serializer symbol).
package phy_tx_pkg;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam logic [7:0] IDL_SYM = 8'h7C;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       k;
        logic       lane;
    } ser_sym_t;

endpackage

// File: rtl/phy_tx_if.sv
// rtl/phy_tx_if.sv - lane input and serializer output bundle of the PHY transmit scheduler
//
// Purpose : groups the two lane byte streams and the serializer handshake.
// Modports: slave  - scheduler view (lanes in, serializer out)
//           master - producer/serializer view (lanes out, serializer in)
interface phy_tx_if;

    logic       valid_data_0;
    logic [7:0] data_in_0;
    logic       ready_0;
    logic       valid_data_1;
    logic [7:0] data_in_1;
    logic       ready_1;
    logic       ser_ready;
    logic       ser_valid;
    logic [7:0] ser_data;
    logic       ser_k;
    logic       ser_lane;

    modport slave (
        input  valid_data_0, data_in_0, valid_data_1, data_in_1, ser_ready,
        output ready_0, ready_1, ser_valid, ser_data, ser_k, ser_lane
    );

    modport master (
        output valid_data_0, data_in_0, valid_data_1, data_in_1, ser_ready,
        input  ready_0, ready_1, ser_valid, ser_data, ser_k, ser_lane
    );

endinterface

// File: rtl/phy_tx_fifo.sv
// rtl/phy_tx_fifo.sv - per-lane synchronous byte FIFO
//
// Purpose : power-of-two deep FIFO with first-word-visible head.
// Ports   : clk, rst (async active-high)
//           push_i/data_i  - write (ignored while full)
//           pop_i          - read (ignored while empty)
//           full_o/empty_o - occupancy flags
//           head_o         - oldest entry
module phy_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Depth is a power of two, so natural pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says so.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/phy_tx_sched.sv
// rtl/phy_tx_sched.sv - two-lane byte transmit scheduler with COM bring-up and IDL fill
//
// Purpose : buffers two lane byte streams, sends an INIT_SYMS-long COM burst
//           after enable, then round-robins lane bytes onto one serializer,
//           filling empty slots with IDL.
// Ports   : clk_2f  - byte clock
//           reset   - async active-high clear
//           enable  - link enable (level)
//           bus     - phy_tx_if.slave: lane inputs, ready_x, serializer outputs
module phy_tx_sched
    import phy_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         INIT_SYMS  = 4,
    parameter logic [7:0] COM        = COM_SYM,
    parameter logic [7:0] IDL        = IDL_SYM
) (
    input  logic     clk_2f,
    input  logic     reset,
    input  logic     enable,
    phy_tx_if.slave  bus
);

    localparam logic [7:0] INIT_LAST = 8'(INIT_SYMS);

    logic [1:0] state_q, state_d;
    logic [7:0] init_cnt_q, init_cnt_d;
    logic [7:0] init_next;
    logic       last_lane_q, last_lane_d;
    ser_sym_t   out_q, out_d;

    logic       full_0, empty_0, full_1, empty_1;
    logic [7:0] head_0, head_1;
    logic       pop_0, pop_1;
    logic       load, com_acc, run_load;
    logic       pick_valid, pick_lane;

    assign bus.ready_0 = !full_0 && !reset;
    assign bus.ready_1 = !full_1 && !reset;

    phy_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo_0 (
        .clk     (clk_2f),
        .rst     (reset),
        .push_i  (bus.valid_data_0 && bus.ready_0),
        .data_i  (bus.data_in_0),
        .pop_i   (pop_0),
        .full_o  (full_0),
        .empty_o (empty_0),
        .head_o  (head_0)
    );

    phy_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo_1 (
        .clk     (clk_2f),
        .rst     (reset),
        .push_i  (bus.valid_data_1 && bus.ready_1),
        .data_i  (bus.data_in_1),
        .pop_i   (pop_1),
        .full_o  (full_1),
        .empty_o (empty_1),
        .head_o  (head_1)
    );

    assign load = !out_q.valid || bus.ser_ready;

    // A COM currently on the output that the serializer takes this edge.
    assign com_acc   = (state_q == ST_INIT) && out_q.valid && out_q.k &&
                       (out_q.data == COM) && bus.ser_ready;
    assign init_next = init_cnt_q + {7'd0, com_acc};

    // Both lanes pending: alternate away from the last served lane.
    // Only lane 1 pending: empty_0 is 1, which selects lane 1.
    assign pick_valid = !empty_0 || !empty_1;
    assign pick_lane  = (!empty_0 && !empty_1) ? !last_lane_q : empty_0;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        last_lane_d = last_lane_q;
        out_d       = out_q;
        run_load    = 1'b0;
        pop_0       = 1'b0;
        pop_1       = 1'b0;

        case (state_q)
            ST_OFF: begin
                init_cnt_d = '0;
                if (load) out_d = '0;
                if (enable) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (load) begin
                    if (!enable) begin
                        state_d = ST_OFF;
                        out_d   = '0;
                    end else begin
                        init_cnt_d = init_next;
                        // The final COM leaves this edge; the slot it frees
                        // already belongs to RUN so no extra COM goes out.
                        if (init_next == INIT_LAST) begin
                            state_d  = ST_RUN;
                            run_load = 1'b1;
                        end else begin
                            out_d.valid = 1'b1;
                            out_d.data  = COM;
                            out_d.k     = 1'b1;
                            out_d.lane  = 1'b0;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (load) begin
                    if (!enable) begin
                        state_d = ST_OFF;
                        out_d   = '0;
                    end else begin
                        run_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                out_d   = '0;
            end
        endcase

        if (run_load) begin
            out_d.valid = 1'b1;
            if (pick_valid) begin
                out_d.data  = pick_lane ? head_1 : head_0;
                out_d.k     = 1'b0;
                out_d.lane  = pick_lane;
                last_lane_d = pick_lane;
                pop_0       = !pick_lane;
                pop_1       = pick_lane;
            end else begin
                out_d.data = IDL;
                out_d.k    = 1'b1;
                out_d.lane = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OFF;
            init_cnt_q  <= '0;
            last_lane_q <= 1'b1;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            last_lane_q <= last_lane_d;
            out_q       <= out_d;
        end
    end

    assign bus.ser_valid = out_q.valid;
    assign bus.ser_data  = out_q.data;
    assign bus.ser_k     = out_q.k;
    assign bus.ser_lane  = out_q.lane;

endmodule
